// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and small bit helpers.
// Intended for both the receiver and the planned transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_IDLE = 3'd6
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Data is zero-extended to 9 bits; the extra zeros do not change the XOR.
    function automatic logic parity_error(input logic [8:0] data, input logic par_bit,
                                          input logic [1:0] mode);
        logic err;
        case (mode)
            PAR_EVEN: err = (^data) ^ par_bit;
            PAR_ODD:  err = ~((^data) ^ par_bit);
            default:  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the asynchronous RX pin plus the 3-sample history
// used for the per-bit majority vote.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic i_Rx_Serial,
    input  logic sample_en,
    output logic rx_s,
    output logic maj
);

    logic       sync1_r;
    logic       sync2_r;
    logic [1:0] hist_r;

    // Synchronise the pin; the line idles high so both flops reset to 1.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= i_Rx_Serial;
            sync2_r <= sync1_r;
        end
    end

    // Capture the two samples preceding the sample point; the third is the live rx_s.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hist_r <= 2'b11;
        end else if (sample_en) begin
            hist_r <= {hist_r[0], sync2_r};
        end else begin
            hist_r <= hist_r;
        end
    end

    assign rx_s = sync2_r;
    assign maj  = majority3(hist_r[1], hist_r[0], sync2_r);

endmodule

// File: rtl/uart_receiver_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/odd/even parity, 1 or 2 stop bits,
// majority-voted bit sampling with parity, framing and break detection.
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Rx_Serial,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam logic [CNT_W-1:0] MID_C      = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_C     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
    localparam logic [1:0]       PAR_MODE_C = 2'(PARITY_MODE);
    localparam logic             HAS_PARITY = (PAR_MODE_C != PAR_NONE);
    localparam logic [3:0]       LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic             LAST_STOP  = 1'(STOP_BITS - 1);

    uart_state_t          state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [3:0]           bit_idx_r;
    logic                 stop_idx_r;
    logic [DATA_BITS-1:0] data_r;
    logic                 par_bit_r;
    logic                 stop_low_any_r;
    logic                 stop_high_any_r;
    logic                 busy_r;
    logic                 rx_dv_r;
    logic [DATA_BITS-1:0] rx_byte_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 break_r;

    logic                 rx_s;
    logic                 maj_s;
    logic [CNT_W-1:0]     point_s;
    logic                 at_point_s;
    logic                 sample_en_s;

    uart_rx_sampler u_sampler (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Rx_Serial (i_Rx_Serial),
        .sample_en   (sample_en_s),
        .rx_s        (rx_s),
        .maj         (maj_s)
    );

    // Sample point of the current bit and the two history captures just before it.
    always_comb begin
        point_s     = LAST_C;
        at_point_s  = 1'b0;
        sample_en_s = 1'b0;
        if (state_r == START) begin
            point_s = MID_C;
        end else begin
            point_s = LAST_C;
        end
        if ((state_r == START) || (state_r == DATA) || (state_r == PARITY) || (state_r == STOP)) begin
            at_point_s  = (cnt_r == point_s);
            sample_en_s = (cnt_r == point_s - CNT_TWO) || (cnt_r == point_s - CNT_ONE);
        end else begin
            at_point_s  = 1'b0;
            sample_en_s = 1'b0;
        end
    end

    // Receive FSM; every state change clears the bit-period counter.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= CNT_ZERO;
            bit_idx_r       <= 4'd0;
            stop_idx_r      <= 1'b0;
            data_r          <= {DATA_BITS{1'b0}};
            par_bit_r       <= 1'b0;
            stop_low_any_r  <= 1'b0;
            stop_high_any_r <= 1'b0;
            busy_r          <= 1'b0;
            rx_dv_r         <= 1'b0;
            rx_byte_r       <= {DATA_BITS{1'b0}};
            parity_err_r    <= 1'b0;
            frame_err_r     <= 1'b0;
            break_r         <= 1'b0;
        end else begin
            rx_dv_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rx_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (at_point_s) begin
                        cnt_r <= CNT_ZERO;
                        if (!maj_s) begin
                            state_r         <= DATA;
                            bit_idx_r       <= 4'd0;
                            stop_idx_r      <= 1'b0;
                            par_bit_r       <= 1'b0;
                            stop_low_any_r  <= 1'b0;
                            stop_high_any_r <= 1'b0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (at_point_s) begin
                        cnt_r  <= CNT_ZERO;
                        data_r <= {maj_s, data_r[DATA_BITS-1:1]};
                        if (bit_idx_r == LAST_BIT) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= HAS_PARITY ? PARITY : STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 4'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                PARITY: begin
                    if (at_point_s) begin
                        cnt_r     <= CNT_ZERO;
                        par_bit_r <= maj_s;
                        state_r   <= STOP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    if (at_point_s) begin
                        cnt_r <= CNT_ZERO;
                        if (stop_idx_r == LAST_STOP) begin
                            state_r      <= DONE;
                            rx_dv_r      <= 1'b1;
                            rx_byte_r    <= data_r;
                            parity_err_r <= parity_error(9'(data_r), par_bit_r, PAR_MODE_C);
                            frame_err_r  <= stop_low_any_r | ~maj_s;
                            break_r      <= (data_r == {DATA_BITS{1'b0}})
                                            & (~HAS_PARITY | ~par_bit_r)
                                            & ~(stop_high_any_r | maj_s);
                        end else begin
                            stop_idx_r      <= 1'b1;
                            stop_low_any_r  <= stop_low_any_r | ~maj_s;
                            stop_high_any_r <= stop_high_any_r | maj_s;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= break_r ? WAIT_IDLE : IDLE;
                    busy_r  <= break_r;
                end
                WAIT_IDLE: begin
                    // A break only ends after a full bit period of continuous idle.
                    if (!rx_s) begin
                        cnt_r <= CNT_ZERO;
                    end else if (cnt_r == LAST_C) begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Rx_DV      = rx_dv_r;
    assign o_Rx_Byte    = rx_byte_r;
    assign o_Parity_Err = parity_err_r;
    assign o_Frame_Err  = frame_err_r;
    assign o_Break      = break_r;
    assign o_Busy       = busy_r;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Self-checking bench for uart_receiver_cfg: three instances (8N1, 8E1, 7N2) at 16 clocks/bit,
// checked every cycle against a frame-level model plus literal expectations.
module tb_uart_receiver_cfg;

    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] b;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rx_line [3];

    logic       dv0, dv1, dv2;
    logic [7:0] byte0, byte1;
    logic [6:0] byte2;
    logic       pe0, pe1, pe2, fe0, fe1, fe2, brk0, brk1, brk2, busy0, busy1, busy2;

    logic       obs_dv   [3];
    logic [8:0] obs_b    [3];
    logic       obs_pe   [3];
    logic       obs_fe   [3];
    logic       obs_brk  [3];
    logic       obs_busy [3];

    exp_t expq [3][$];
    exp_t held [3];
    int   dv_cnt [3];
    int   dv_cyc [3];
    int   start_cyc [3];
    int   ncyc;
    int   checks;
    int   failures;

    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[0]), .o_Rx_DV(dv0), .o_Rx_Byte(byte0),
        .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(brk0), .o_Busy(busy0));
    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[1]), .o_Rx_DV(dv1), .o_Rx_Byte(byte1),
        .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(brk1), .o_Busy(busy1));
    uart_receiver_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Rx_Serial(rx_line[2]), .o_Rx_DV(dv2), .o_Rx_Byte(byte2),
        .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(brk2), .o_Busy(busy2));

    assign obs_dv[0] = dv0;  assign obs_b[0] = {1'b0, byte0};  assign obs_pe[0] = pe0;
    assign obs_dv[1] = dv1;  assign obs_b[1] = {1'b0, byte1};  assign obs_pe[1] = pe1;
    assign obs_dv[2] = dv2;  assign obs_b[2] = {2'b00, byte2}; assign obs_pe[2] = pe2;
    assign obs_fe[0] = fe0;  assign obs_brk[0] = brk0; assign obs_busy[0] = busy0;
    assign obs_fe[1] = fe1;  assign obs_brk[1] = brk1; assign obs_busy[1] = busy1;
    assign obs_fe[2] = fe2;  assign obs_brk[2] = brk2; assign obs_busy[2] = busy2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, ncyc);
        end
    endtask

    // Frame-level model: what a receiver must report for the bits placed on the line.
    function automatic exp_t model(input logic [8:0] data, input int nbits, input int mode,
                                   input logic pbit, input logic [1:0] stops, input int nstops);
        exp_t       e;
        logic [8:0] d;
        int         ones;
        logic       any_low;
        logic       all_low;
        d = 9'd0;
        for (int k = 0; k < nbits; k++) d[k] = data[k];
        ones = $countones(d) + ((mode != 0) ? int'(pbit) : 0);
        any_low = 1'b0;
        all_low = 1'b1;
        for (int s = 0; s < nstops; s++) begin
            if (stops[s] == 1'b0) any_low = 1'b1;
            else                  all_low = 1'b0;
        end
        e.b   = d;
        e.pe  = (mode == 1) ? (ones % 2 == 0) : (mode == 2) ? (ones % 2 == 1) : 1'b0;
        e.fe  = any_low;
        e.brk = (d == 9'd0) && ((mode == 0) || (pbit == 1'b0)) && all_low;
        return e;
    endfunction

    // Advance one clock and compare every instance against the model at the falling edge.
    task automatic tick();
        @(negedge clk);
        ncyc++;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) held[i] = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (obs_dv[i]) begin
                    dv_cnt[i]++;
                    dv_cyc[i] = ncyc;
                    checks++;
                    if (expq[i].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_dv inst%0d: got dv=1 expected dv=0 (cycle %0d)", i, ncyc);
                    end else begin
                        held[i] = expq[i].pop_front();
                    end
                end
                check($sformatf("outputs_inst%0d{byte,pe,fe,brk}", i),
                      16'({obs_b[i], obs_pe[i], obs_fe[i], obs_brk[i]}), 16'(held[i]));
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic drive_bit(input int idx, input logic v);
        rx_line[idx] = v;
        ticks(CPB);
    endtask

    task automatic send_frame(input int idx, input logic [8:0] data, input int nbits, input int mode,
                              input logic pbit, input logic [1:0] stops, input int nstops);
        expq[idx].push_back(model(data, nbits, mode, pbit, stops, nstops));
        start_cyc[idx] = ncyc;
        drive_bit(idx, 1'b0);
        for (int k = 0; k < nbits; k++) drive_bit(idx, data[k]);
        if (mode != 0) drive_bit(idx, pbit);
        for (int s = 0; s < nstops; s++) drive_bit(idx, stops[s]);
        rx_line[idx] = 1'b1;
        ticks(2 * CPB);
    endtask

    initial begin
        int dv_before;
        int n;
        checks   = 0;
        failures = 0;
        ncyc     = 0;
        for (int i = 0; i < 3; i++) begin
            rx_line[i] = 1'b1;
            held[i]    = '0;
            dv_cnt[i]  = 0;
            dv_cyc[i]  = 0;
            start_cyc[i] = 0;
        end
        rst_n = 1'b0;
        ticks(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_outputs_inst%0d", i),
                  16'({obs_dv[i], obs_b[i], obs_pe[i], obs_fe[i], obs_brk[i], obs_busy[i]}), 16'h0000);
        rst_n = 1'b1;
        ticks(CPB);

        // 8N1 0xA5: one DV, 155 clocks after the start edge is driven.
        dv_before = dv_cnt[0];
        send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        check("t1_dv_count", 16'(dv_cnt[0] - dv_before), 16'd1);
        check("t1_latency", 16'(dv_cyc[0] - start_cyc[0]), 16'd155);
        check("t1_byte", 16'(byte0), 16'h00A5);
        check("t1_flags", 16'({pe0, fe0, brk0}), 16'h0000);

        // 8E1 0x03: parity bit 1 is wrong for even parity, 0 is right.
        send_frame(1, 9'h003, 8, 2, 1'b1, 2'b11, 1);
        check("t2a_byte", 16'(byte1), 16'h0003);
        check("t2a_parity_err", 16'(pe1), 16'h0001);
        check("t2a_frame_err", 16'(fe1), 16'h0000);
        send_frame(1, 9'h003, 8, 2, 1'b0, 2'b11, 1);
        check("t2b_parity_err", 16'(pe1), 16'h0000);

        // 7N2 0x55 with second stop low, then a clean 0x2A.
        send_frame(2, 9'h055, 7, 0, 1'b0, 2'b01, 2);
        check("t3a_byte", 16'(byte2), 16'h0055);
        check("t3a_frame_err", 16'(fe2), 16'h0001);
        check("t3a_break", 16'(brk2), 16'h0000);
        send_frame(2, 9'h02A, 7, 0, 1'b0, 2'b11, 2);
        check("t3b_byte", 16'(byte2), 16'h002A);
        check("t3b_flags", 16'({pe2, fe2, brk2}), 16'h0000);

        // Glitch: 5 low clocks are rejected and the FSM returns to idle quickly.
        dv_before = dv_cnt[0];
        rx_line[0] = 1'b0;
        ticks(5);
        rx_line[0] = 1'b1;
        check("t4_start_taken", 16'(busy0), 16'h0001);
        n = 0;
        while (busy0 && n < 8) begin
            tick();
            n++;
        end
        check("t4_idle_within_8", 16'(busy0), 16'h0000);
        ticks(2 * CPB);
        check("t4_no_dv", 16'(dv_cnt[0] - dv_before), 16'd0);

        // Break: 20 bit times low, one DV, then held off until 16 idle clocks.
        dv_before = dv_cnt[0];
        expq[0].push_back(model(9'h000, 8, 0, 1'b0, 2'b00, 1));
        rx_line[0] = 1'b0;
        ticks(20 * CPB);
        rx_line[0] = 1'b1;
        ticks(8);
        check("t5_dv_count", 16'(dv_cnt[0] - dv_before), 16'd1);
        check("t5_break_flags", 16'({byte0, brk0, fe0, pe0}), 16'b0000_0000_110);
        check("t5_wait_idle_busy", 16'(busy0), 16'h0001);
        ticks(24);
        check("t5_idle_after_gap", 16'(busy0), 16'h0000);
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1);
        check("t5_recover_byte", 16'(byte0), 16'h003C);

        // Reset in the middle of data bit 3 abandons the frame.
        dv_before = dv_cnt[0];
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rx_line[0] = 1'b1;
        ticks(CPB / 2);
        rst_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 16'({dv0, byte0, pe0, fe0, brk0, busy0}), 16'h0000);
        ticks(3);
        rst_n = 1'b1;
        ticks(2 * CPB);
        check("t6_no_dv", 16'(dv_cnt[0] - dv_before), 16'd0);
        check("t6_idle", 16'(busy0), 16'h0000);
        send_frame(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1);
        check("t6_next_byte", 16'(byte0), 16'h00C3);
        check("t6_next_flags", 16'({pe0, fe0, brk0}), 16'h0000);

        for (int i = 0; i < 3; i++)
            check($sformatf("missing_dv_inst%0d", i), 16'(expq[i].size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
